// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit serial back end:
// FSM state encoding, default timing parameters and line-level codes.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DATA    = 3'd1,
    ST_STUFF   = 3'd2,
    ST_EOP_HS  = 3'd3,
    ST_EOP_SE0 = 3'd4,
    ST_EOP_J   = 3'd5
  } tx_state_e;

  localparam int STUFF_LIMIT_DEF = 6;
  localparam int HS_EOP_BITS_DEF = 8;
  localparam int FS_SE0_BITS_DEF = 2;

  // {dp, dm} line codes
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/tx_bit_stuffer_nrzi_encoder.sv
// Registered NRZI line level with J-load, toggle and SE0 controls; all
// updates happen only on bit_en so the line is stable between bit times.
module nrzi_encoder import usb_tx_pkg::*; (
  input  logic clk,
  input  logic rst_b,
  input  logic bit_en,
  input  logic load_j,
  input  logic toggle,
  input  logic se0,
  output logic tx_dp,
  output logic tx_dm
);

  logic level_q, level_d;
  logic se0_q, se0_d;

  always_comb begin
    level_d = level_q;
    se0_d   = se0_q;
    if (bit_en) begin
      if (load_j) begin
        level_d = 1'b1;
        se0_d   = 1'b0;
      end else if (se0) begin
        se0_d = 1'b1;
      end else begin
        se0_d = 1'b0;
        if (toggle) level_d = ~level_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      level_q <= 1'b1;
      se0_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      se0_q   <= se0_d;
    end
  end

  assign {tx_dp, tx_dm} = se0_q ? LINE_SE0 : (level_q ? LINE_J : LINE_K);

endmodule

// File: rtl/tx_bit_stuffer.sv
// USB TX back end: bit stuffing, NRZI and HS/FS EOP generation.
// Optional stuff-error injection port under USB_TX_STUFF_ERR_INJ_EN.
module tx_bit_stuffer import usb_tx_pkg::*; #(
  parameter int STUFF_LIMIT = STUFF_LIMIT_DEF,
  parameter int HS_EOP_BITS = HS_EOP_BITS_DEF,
  parameter int FS_SE0_BITS = FS_SE0_BITS_DEF
) (
  input  logic clk,
  input  logic rst_b,
  input  logic bit_en,
  input  logic hs_mode,
  input  logic shift_reg_out,
  input  logic shift_reg_out_valid,
  input  logic packet_end,
`ifdef USB_TX_STUFF_ERR_INJ_EN
  input  logic inj_stuff_err,
`endif
  output logic bit_stuff_ready,
  output logic bit_stuffed,
  output logic tx_dp,
  output logic tx_dm,
  output logic tx_oe
);

  localparam logic [2:0] ONES_LIM = 3'(STUFF_LIMIT);
  localparam logic [2:0] HS_LAST  = 3'(HS_EOP_BITS - 1);
  localparam logic [2:0] SE0_LAST = 3'(FS_SE0_BITS - 1);

  tx_state_e  state_q, state_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic       oe_q, oe_d;
  logic       stuffed_q, stuffed_d;
  logic       hs_q, hs_d;
  logic       pend_q, pend_d;

  logic       stuff_due, xfer, eop_hs, at_limit;
  logic [2:0] ones_inc;
  tx_state_e  eop_state;
  logic       load_j, toggle, se0;
  logic       inj_hit;

`ifdef USB_TX_STUFF_ERR_INJ_EN
  logic inj_arm_q, inj_arm_d;
  assign inj_hit = inj_arm_q || (state_q == ST_DATA && inj_stuff_err);
`else
  assign inj_hit = 1'b0;
`endif

  assign stuff_due       = (ones_q == ONES_LIM);
  assign bit_stuff_ready = (state_q == ST_IDLE || state_q == ST_DATA) && !stuff_due;
  assign xfer            = bit_en && shift_reg_out_valid && bit_stuff_ready;
  assign eop_hs          = (state_q == ST_IDLE) ? hs_mode : hs_q;
  assign eop_state       = eop_hs ? ST_EOP_HS : ST_EOP_SE0;
  assign ones_inc        = shift_reg_out ? ones_q + 3'd1 : 3'd0;
  assign at_limit        = (ones_inc == ONES_LIM);

  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    bcnt_d    = bcnt_q;
    oe_d      = oe_q;
    hs_d      = hs_q;
    pend_d    = pend_q;
    stuffed_d = 1'b0;
    load_j    = 1'b0;
    toggle    = 1'b0;
    se0       = 1'b0;
`ifdef USB_TX_STUFF_ERR_INJ_EN
    inj_arm_d = inj_arm_q;
    if (state_q == ST_IDLE) inj_arm_d = 1'b0;
    else if (bit_en && state_q == ST_DATA && inj_stuff_err) inj_arm_d = 1'b1;
    if (xfer && at_limit && inj_hit) inj_arm_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        ones_d = 3'd0;
        bcnt_d = 3'd0;
        pend_d = 1'b0;
        hs_d   = hs_mode;
        load_j = 1'b1;
      end
      ST_DATA: begin
        // No data offered but the packet is over: first EOP bit goes out now.
        if (bit_en && !xfer && packet_end) begin
          state_d = eop_state;
          bcnt_d  = 3'd0;
          pend_d  = 1'b0;
          if (eop_hs) toggle = 1'b1;
          else        se0    = 1'b1;
        end
      end
      ST_STUFF: begin
        if (bit_en) begin
          toggle    = 1'b1;
          stuffed_d = 1'b1;
          ones_d    = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_EOP_HS: begin
        if (bit_en) begin
          if (pend_q) begin
            toggle = 1'b1;
            pend_d = 1'b0;
          end else if (bcnt_q == HS_LAST) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            load_j  = 1'b1;
            bcnt_d  = 3'd0;
          end else begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end
      end
      ST_EOP_SE0: begin
        if (bit_en) begin
          if (pend_q) begin
            se0    = 1'b1;
            pend_d = 1'b0;
          end else if (bcnt_q == SE0_LAST) begin
            state_d = ST_EOP_J;
            load_j  = 1'b1;
            bcnt_d  = 3'd0;
          end else begin
            se0    = 1'b1;
            bcnt_d = bcnt_q + 3'd1;
          end
        end
      end
      ST_EOP_J: begin
        if (bit_en) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
          load_j  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Accepted data bit; a bit carrying packet_end parks in the EOP state
    // with its first bit pending for the next bit time.
    if (xfer) begin
      load_j = 1'b0;
      toggle = !shift_reg_out;
      oe_d   = 1'b1;
      hs_d   = eop_hs;
      if (at_limit && !inj_hit) begin
        ones_d  = ones_inc;
        state_d = ST_STUFF;
      end else begin
        ones_d = at_limit ? 3'd0 : ones_inc;
        if (packet_end) begin
          state_d = eop_state;
          pend_d  = 1'b1;
          bcnt_d  = 3'd0;
        end else begin
          state_d = ST_DATA;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= ST_IDLE;
      ones_q    <= 3'd0;
      bcnt_q    <= 3'd0;
      oe_q      <= 1'b0;
      stuffed_q <= 1'b0;
      hs_q      <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      bcnt_q    <= bcnt_d;
      oe_q      <= oe_d;
      stuffed_q <= stuffed_d;
      hs_q      <= hs_d;
      pend_q    <= pend_d;
    end
  end

`ifdef USB_TX_STUFF_ERR_INJ_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) inj_arm_q <= 1'b0;
    else        inj_arm_q <= inj_arm_d;
  end
`endif

  nrzi_encoder u_nrzi (
    .clk    (clk),
    .rst_b  (rst_b),
    .bit_en (bit_en),
    .load_j (load_j),
    .toggle (toggle),
    .se0    (se0),
    .tx_dp  (tx_dp),
    .tx_dm  (tx_dm)
  );

  assign tx_oe       = oe_q;
  assign bit_stuffed = stuffed_q;

endmodule

// File: tb/tb_tx_bit_stuffer.sv
// Directed bench for tx_bit_stuffer: HS vector table plus reset, FS EOP
// and (with USB_TX_STUFF_ERR_INJ_EN) stuff-error injection sequences.
module tb_tx_bit_stuffer;

  localparam logic [1:0] J = 2'b10;
  localparam logic [1:0] K = 2'b01;
  localparam logic [1:0] S = 2'b00;

  logic clk = 1'b0;
  logic rst_b, bit_en, hs_mode, data, valid, pe;
  logic ready, stuffed, dp, dm, oe;
`ifdef USB_TX_STUFF_ERR_INJ_EN
  logic inj;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic       v, d, pe, rdy;
    logic [1:0] line;
    logic       oe, st;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  tx_bit_stuffer dut (
    .clk                 (clk),
    .rst_b               (rst_b),
    .bit_en              (bit_en),
    .hs_mode             (hs_mode),
    .shift_reg_out       (data),
    .shift_reg_out_valid (valid),
    .packet_end          (pe),
`ifdef USB_TX_STUFF_ERR_INJ_EN
    .inj_stuff_err       (inj),
`endif
    .bit_stuff_ready     (ready),
    .bit_stuffed         (stuffed),
    .tx_dp               (dp),
    .tx_dm               (dm),
    .tx_oe               (oe)
  );

  function automatic vec_t mk(input logic v, d, p, r, input logic [1:0] l, input logic o, s);
    vec_t x;
    x.v = v; x.d = d; x.pe = p; x.rdy = r; x.line = l; x.oe = o; x.st = s;
    return x;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply_row(input vec_t r, input string tag, input int idx);
    @(negedge clk);
    bit_en = 1'b1; valid = r.v; data = r.d; pe = r.pe;
    #1 chk({tag, ".rdy"}, idx, {7'd0, ready}, {7'd0, r.rdy});
    @(posedge clk); #1;
    chk({tag, ".line"}, idx, {6'd0, dp, dm}, {6'd0, r.line});
    chk({tag, ".oe"}, idx, {7'd0, oe}, {7'd0, r.oe});
    chk({tag, ".stuffed"}, idx, {7'd0, stuffed}, {7'd0, r.st});
  endtask

  logic [2:0] fs_prev;
  int         fs_idx;

  task automatic fs_bit(input logic v, d, p, input logic [1:0] el, input logic eo);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bit_en = (c == 3); valid = v; data = d; pe = p;
      @(posedge clk); #1;
      if (c < 3) chk("fs.hold", fs_idx, {5'd0, dp, dm, oe}, {5'd0, fs_prev});
      else       chk("fs.bit", fs_idx, {5'd0, dp, dm, oe}, {5'd0, el, eo});
    end
    fs_prev = {el, eo};
    fs_idx++;
  endtask

  initial begin
    rst_b = 1'b0; bit_en = 1'b1; hs_mode = 1'b1; data = 1'b0; valid = 1'b0; pe = 1'b0;
`ifdef USB_TX_STUFF_ERR_INJ_EN
    inj = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst.line", 0, {6'd0, dp, dm}, {6'd0, J});
    chk("rst.oe", 0, {7'd0, oe}, 8'd0);
    chk("rst.stuffed", 0, {7'd0, stuffed}, 8'd0);
    chk("rst.rdy", 0, {7'd0, ready}, 8'd1);
    @(negedge clk) rst_b = 1'b1;

    // HS stream 0x80, 0xFF (LSB first) with stuff bit, packet_end on last bit
    for (int i = 0; i < 7; i++) tbl.push_back(mk(1, 0, 0, 1, (i % 2 == 0) ? K : J, 1, 0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 1, 0, 1, K, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, J, 1, 1));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 1, 0, 1, J, 1, 0));
    tbl.push_back(mk(1, 1, 1, 1, J, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, K, 1, 0));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 0, 0, 0, K, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, J, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, J, 0, 0));
    // six 1s, then packet_end: stuff bit first, then HS EOP
    for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 1, 0, 1, J, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, K, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, J, 1, 0));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 0, 0, 0, J, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, J, 0, 0));
    // back-to-back: valid held through EOP; second packet restarts from J
    tbl.push_back(mk(1, 0, 0, 1, K, 1, 0));
    tbl.push_back(mk(1, 0, 1, 1, J, 1, 0));
    tbl.push_back(mk(1, 1, 1, 0, K, 1, 0));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(1, 1, 0, 0, K, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, J, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, J, 1, 0));
    tbl.push_back(mk(1, 0, 1, 1, K, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, J, 1, 0));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 0, 0, 0, J, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, J, 0, 0));

    foreach (tbl[i]) apply_row(tbl[i], "hs", i);

    // reset in the middle of a packet, ones counter at 2
    apply_row(mk(1, 0, 0, 1, K, 1, 0), "pre_rst", 0);
    apply_row(mk(1, 1, 0, 1, K, 1, 0), "pre_rst", 1);
    apply_row(mk(1, 1, 0, 1, K, 1, 0), "pre_rst", 2);
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("midrst.line", 0, {6'd0, dp, dm}, {6'd0, J});
    chk("midrst.oe", 0, {7'd0, oe}, 8'd0);
    chk("midrst.rdy", 0, {7'd0, ready}, 8'd1);
    @(negedge clk) rst_b = 1'b1;
    valid = 1'b0;
    for (int i = 0; i < 5; i++) apply_row(mk(1, 1, 0, 1, J, 1, 0), "post_rst", i);
    apply_row(mk(0, 0, 1, 1, K, 1, 0), "post_rst", 5);
    for (int i = 0; i < 7; i++) apply_row(mk(0, 0, 0, 0, K, 1, 0), "post_rst", 6 + i);
    apply_row(mk(0, 0, 0, 0, J, 0, 0), "post_rst", 13);

    // FS: bit_en every 4th clk, byte 0x00, then SE0 x2 and J
    hs_mode = 1'b1;
    @(negedge clk) hs_mode = 1'b0;
    fs_prev = {J, 1'b0};
    fs_idx  = 0;
    for (int i = 0; i < 8; i++) fs_bit(1, 0, 0, (i % 2 == 0) ? K : J, 1);
    fs_bit(0, 0, 1, S, 1);
    fs_bit(0, 0, 0, S, 1);
    fs_bit(0, 0, 0, J, 1);
    fs_bit(0, 0, 0, J, 0);
    @(negedge clk);
    bit_en = 1'b1; hs_mode = 1'b1;

`ifdef USB_TX_STUFF_ERR_INJ_EN
    // injection: seven 1s with no stuff bit
    inj = 1'b1;
    for (int i = 0; i < 7; i++) apply_row(mk(1, 1, 0, 1, J, 1, 0), "inj", i);
    inj = 1'b0;
    apply_row(mk(0, 0, 1, 1, K, 1, 0), "inj", 7);
    for (int i = 0; i < 7; i++) apply_row(mk(0, 0, 0, 0, K, 1, 0), "inj", 8 + i);
    apply_row(mk(0, 0, 0, 0, J, 0, 0), "inj", 15);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_bit_stuffer.md
# tx_bit_stuffer

Serial back end of the USB 2.0 transmit path. It sits directly downstream of `tx_state_machine`, which supplies one bit per bit time over a valid/ready handshake. The block inserts a stuff `0` after six consecutive `1`s, NRZI-encodes the stream and generates the HS or FS end-of-packet. It drives the line-level signals (`tx_dp`, `tx_dm`, `tx_oe`) consumed by the analog driver.

## Interface
- `STUFF_LIMIT`, 6: consecutive `1`s that force a stuff bit.
- `HS_EOP_BITS`, 8: HS EOP length in bit times.
- `FS_SE0_BITS`, 2: FS EOP SE0 length in bit times.
- `clk` input 1: bit clock; all logic on posedge.
- `rst_b` input 1: asynchronous, active-low reset.
- `bit_en` input 1: bit-time strobe. Tie high in HS; one pulse per FS bit time.
- `hs_mode` input 1: 1 = HS EOP rules, 0 = FS EOP rules. Sampled only in IDLE.
- `shift_reg_out` input 1: data bit from upstream.
- `shift_reg_out_valid` input 1: data bit valid.
- `packet_end` input 1: last data bit already handed over; request EOP.
- `bit_stuff_ready` output 1: block accepts a data bit this cycle.
- `bit_stuffed` output 1: one-cycle pulse on the bit time a stuff bit is driven.
- `tx_dp`, `tx_dm` output 1 each: line levels. J = 1/0, K = 0/1, SE0 = 0/0.
- `tx_oe` output 1: driver enable.

## Operation
- States: IDLE, DATA, STUFF, EOP_HS, EOP_SE0, EOP_J.
- A bit transfers when `bit_en && shift_reg_out_valid && bit_stuff_ready`.
- `bit_stuff_ready` = `(state==IDLE || state==DATA) && !stuff_due`. It is combinational from registered state.
- **IDLE**
  - Line is J and `tx_oe`=0.
  - The first transfer moves to DATA and sets `tx_oe`=1.
  - Ones counter cleared.
- **NRZI**
  - Data `0` toggles the line (J↔K); `1` holds it.
  - The NRZI level starts at J for each packet.
- **Ones counter (3 bits)**
  - Increments on each transferred `1`.
  - Clears on a transferred `0`, on a stuff bit, and in IDLE.
  - When it reaches `STUFF_LIMIT`, `stuff_due` is set.
- **DATA**
  - If `stuff_due` is set at the next `bit_en`, go to STUFF.
  - STUFF drives a `0` (toggle) for one bit time, pulses `bit_stuffed`, clears the counter and returns to DATA.
  - `bit_stuff_ready`=0 during the stuff bit time.
- **Valid low in DATA** at a `bit_en` with no `packet_end` and no stuff due: the line holds its level (an underrun). No error is flagged; upstream guarantees this does not happen.
- **`packet_end`**
  - Sampled at `bit_en` in DATA; it is held by upstream until EOP starts.
  - A pending stuff bit is sent first, then EOP.
  - If valid and `packet_end` are both high, the bit transfers and EOP follows at the next bit time.
- **EOP_HS**
  - Drives NRZI `0` then seven `1`s with stuffing disabled: one transition, then the level is held.
  - Lasts `HS_EOP_BITS` bit times, then `tx_oe`=0 and the block returns to IDLE.
- **EOP_SE0 / EOP_J (FS)**
  - SE0 for `FS_SE0_BITS` bit times, then J for 1 bit time.
  - Then `tx_oe`=0 and the block returns to IDLE.
- Bit-time counter: 3 bits, reused for the EOP lengths.

## Timing
- **Reset values:** `tx_dp`=1, `tx_dm`=0, `tx_oe`=0, `bit_stuffed`=0, state IDLE, counters 0. `bit_stuff_ready`=1 after reset.
- Reset mid-packet forces all of the above immediately. No EOP is emitted.
- **Latency:** a bit transferred at edge N appears on `tx_dp`/`tx_dm` after edge N (registered outputs). Line changes only on edges where `bit_en`=1.
- `tx_oe` rises on the same edge as the first data bit. It falls on the edge that ends the final EOP bit time.
- `bit_en`=0 cycles are transparent: state, counters and outputs hold.
- Back-to-back packets: a transfer in the IDLE cycle following EOP completion starts a new packet. Minimum gap is 1 `clk` plus the `bit_en` wait.

## Configuration
- Macro: `USB_TX_STUFF_ERR_INJ_EN`.
- **Defined**
  - Adds input `inj_stuff_err`, sampled in DATA.
  - When set, the next due stuff bit is suppressed: no STUFF state, counter cleared, `bit_stuffed` stays 0. The receiver then sees a stuff error.
- **Undefined:** no port; stuffing always occurs.

## Structure
- `usb_tx_pkg` holds:
  - the state enum;
  - `STUFF_LIMIT`, `HS_EOP_BITS` and `FS_SE0_BITS` defaults;
  - J/K/SE0 line-encoding constants.
- Sub-module `nrzi_encoder`: registered NRZI level with `load_j`, `toggle` and `se0` controls, gated by `bit_en`. This block owns the state machine and counters.

## Test plan
- **Stuffing, HS:** `bit_en`=1, stream 0x80 then 0xFF LSB-first → after the 6th `1`, a K/J toggle with `bit_stuffed` pulse; `bit_stuff_ready`=0 for exactly 1 cycle; 9 line bit times for 8 data bits.
- **Stuff before EOP:** six `1`s, then `packet_end` → stuff bit driven, then 8-bit HS EOP (1 transition, 7 holds), `tx_oe` low after 8 bit times.
- **FS EOP:** `hs_mode`=0, `bit_en` every 4th cycle, byte 0x00, `packet_end` → SE0 for 8 clk, J for 4 clk, `tx_oe`=0; no outputs change between strobes.
- **Reset mid-packet:** `rst_b` low during DATA → `tx_oe`=0 and J immediately; the next packet starts with counter 0 (five `1`s → no stuff).
- **Injection** (`USB_TX_STUFF_ERR_INJ_EN`): `inj_stuff_err`=1, seven `1`s → no stuff bit, `bit_stuffed` never pulses, 7 holds on line.
- **Back-to-back:** valid high through EOP end → second packet's first bit on the first IDLE transfer, `tx_oe` re-asserts, NRZI restarted from J.
